// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-access arbiter.
//   arb_state_t : transaction sequencer states
//   dest_t      : destination codes on the 16-bit register bus
//   REG_BASE    : first valid address of the register resource
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RESP
    } arb_state_t;

    typedef enum logic [15:0] {
        REG = 16'h0000
    } dest_t;

    localparam logic [15:0] REG_BASE = REG;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request levels, one bit per requester
//   rr_ptr  : index that has highest priority this round
//   win_oh  : one-hot winner (all zero when req is zero)
//   win_idx : binary index of the winner
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan from rr_ptr upward, wrapping; the first set bit wins.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        win_idx = '0;
        win_oh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
                win_oh  = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one register-access port among NUM_REQ requesters. Round-robin
// arbitration, one downstream transaction at a time, response routed back
// to the winner. All outputs are registered.
//   req/req_we/req_addr/req_wdata : per-requester request level + payload
//   gnt                           : one-cycle one-hot pulse, payload captured
//   rsp_valid/rsp_rdata/rsp_err   : one-cycle one-hot completion + result
//   reg_req/reg_we/reg_addr/reg_wdata : downstream request, held until ack
//   reg_ack/reg_rdata/reg_err     : downstream completion (one cycle)
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int          NUM_REQ  = 4,
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 32,
    parameter int unsigned REG_SPAN = 32'h0100,
    parameter int          TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      reg_req,
    output logic                      reg_we,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [DATA_W-1:0]         reg_wdata,
    input  logic                      reg_ack,
    input  logic [DATA_W-1:0]         reg_rdata,
    input  logic                      reg_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                reg_req_q, reg_req_d;
    logic                reg_we_q, reg_we_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;

    logic [NUM_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [ADDR_W:0]     addr_off;
    logic                in_range;
    logic [NUM_REQ-1:0]  win_oh_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    // One extra bit so an address below REG_BASE wraps to a huge offset
    // and fails the span check instead of aliasing into range.
    assign sel_addr = req_addr[arb_idx*ADDR_W +: ADDR_W];
    assign addr_off = {1'b0, sel_addr} - (ADDR_W+1)'(REG_BASE);
    assign in_range = addr_off < (ADDR_W+1)'(REG_SPAN);
    assign win_oh_q = NUM_REQ'(1) << win_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        reg_req_d   = reg_req_q;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d       = arb_oh;
                    win_d       = arb_idx;
                    rr_ptr_d    = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                    reg_we_d    = req_we[arb_idx];
                    reg_addr_d  = sel_addr;
                    reg_wdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
                    if (in_range) begin
                        state_d = ISSUE;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: begin
                reg_req_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_d = cnt_q + 16'd1;
                if (reg_ack) begin
                    reg_req_d   = 1'b0;
                    rsp_valid_d = win_oh_q;
                    rsp_rdata_d = reg_we_q ? '0 : reg_rdata;
                    rsp_err_d   = reg_err;
                    state_d     = RESP;
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    reg_req_d   = 1'b0;
                    rsp_valid_d = win_oh_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Completed downstream accesses enter RESP with rsp_valid
                // already showing; an out-of-range reject arrives here with
                // it still low and raises it on the way back to IDLE.
                rsp_valid_d = (rsp_valid_q == '0) ? win_oh_q : '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_req   = reg_req_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model (round-robin pick, expected
// latency, response contents).
module tb_reg_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            reg_req;
    logic            reg_we;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic            reg_ack = 1'b0;
    logic [DW-1:0]   reg_rdata = '0;
    logic            reg_err = 1'b0;

    reg_access_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW),
        .REG_SPAN (32'h0100), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req (req), .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
        .gnt (gnt), .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .reg_req (reg_req), .reg_we (reg_we), .reg_addr (reg_addr), .reg_wdata (reg_wdata),
        .reg_ack (reg_ack), .reg_rdata (reg_rdata), .reg_err (reg_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ptr    = 0;   // model: requester with highest priority next round

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Entered at the negedge of a cycle in which the DUT is idle. d is the
    // number of cycles after reg_req rises before ack is driven; d > TO
    // means no ack at all.
    task automatic txn(input logic [N-1:0] mask, input logic [N-1:0] we,
                       input logic [N*AW-1:0] addrs, input logic [N*DW-1:0] wd,
                       input int d, input logic [DW-1:0] rd, input logic er);
        int            w;
        logic [1:0]    wi;
        logic [AW-1:0] a;
        logic [DW-1:0] erd;
        logic          eer;
        int            last;
        req_we = we; req_addr = addrs; req_wdata = wd; req = mask;
        w   = pick(mask, ptr);
        wi  = 2'(w);
        ptr = (w + 1) % N;
        a   = addrs[w*AW +: AW];
        @(negedge clk);
        // Payload may change after capture; scramble it.
        req = '0; req_addr = {N{16'($urandom)}}; req_wdata = {N{$urandom}}; req_we = ~we;
        chk("gnt", 64'(gnt), 64'(1) << w);
        chk("rsp_before", 64'(rsp_valid), 64'd0);
        if (a >= 16'h0100) begin
            chk("oor_reg_req", 64'(reg_req), 64'd0);
            @(negedge clk);
            chk("oor_rsp_valid", 64'(rsp_valid), 64'(1) << w);
            chk("oor_err", 64'(rsp_err), 64'd1);
            chk("oor_rdata", 64'(rsp_rdata), 64'd0);
            chk("oor_reg_req2", 64'(reg_req), 64'd0);
        end else begin
            last = (d <= TO) ? d : TO;
            for (int k = 0; k <= last; k++) begin
                @(negedge clk);
                chk("reg_req", 64'(reg_req), 64'd1);
                chk("rsp_wait", 64'(rsp_valid), 64'd0);
                if (k == 0) begin
                    chk("reg_addr", 64'(reg_addr), 64'(a));
                    chk("reg_we", 64'(reg_we), 64'(we[wi]));
                    chk("reg_wdata", 64'(reg_wdata), 64'(wd[w*DW +: DW]));
                end
                if (k == d) begin
                    reg_ack = 1'b1; reg_rdata = rd; reg_err = er;
                end
            end
            @(negedge clk);
            // A stray ack while responding must be ignored.
            reg_ack = ($urandom_range(0, 3) == 0); reg_rdata = $urandom; reg_err = 1'($urandom);
            erd = (d <= TO && !we[wi]) ? rd : '0;
            eer = (d <= TO) ? er : 1'b1;
            chk("reg_req_drop", 64'(reg_req), 64'd0);
            chk("rsp_valid", 64'(rsp_valid), 64'(1) << w);
            chk("rsp_rdata", 64'(rsp_rdata), 64'(erd));
            chk("rsp_err", 64'(rsp_err), 64'(eer));
        end
        @(negedge clk);
        reg_ack = 1'b0;
        chk("rsp_pulse", 64'(rsp_valid), 64'd0);
        chk("gnt_idle", 64'(gnt), 64'd0);
        chk("reg_req_idle", 64'(reg_req), 64'd0);
    endtask

    task automatic rand_txn();
        logic [N*AW-1:0] addrs;
        int              d;
        for (int i = 0; i < N; i++)
            addrs[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(256, 65535))
                                                             : 16'($urandom_range(0, 255));
        d = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 11));
        txn(4'($urandom_range(1, 15)), 4'($urandom), addrs,
            {$urandom, $urandom, $urandom, $urandom}, d, $urandom,
            ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        // Reset held with all requesters asking.
        req = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 64'(gnt), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_reg_req", 64'(reg_req), 64'd0);
        end
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_addr", 64'(reg_addr), 64'd0);
        chk("rst_wdata", 64'(reg_wdata), 64'd0);
        chk("rst_we", 64'(reg_we), 64'd0);
        rst_n = 1'b1;

        // Fairness: all requesting, grants 0,1,2,3,0.
        for (int i = 0; i < 5; i++)
            txn(4'hF, 4'h0, {16'h0030, 16'h0020, 16'h0010, 16'h0000},
                {32'h4, 32'h3, 32'h2, 32'h1}, i, 32'h1000 + 32'(i), 1'b0);

        // Single read by requester 2, ack 3 cycles after reg_req.
        txn(4'b0100, 4'h0, {16'h0000, 16'h0010, 16'h0000, 16'h0000},
            '0, 3, 32'hDEADBEEF, 1'b0);
        // Write: read data forced to zero, downstream error passed through.
        txn(4'b0001, 4'h1, {16'h0, 16'h0, 16'h0, 16'h00FF},
            {96'h0, 32'hCAFEF00D}, 1, 32'h12345678, 1'b1);
        // Timeout, then ack coincident with the timeout cycle.
        txn(4'b0010, 4'h0, {16'h0, 16'h0, 16'h0044, 16'h0}, '0, 100, 32'hFFFF, 1'b0);
        txn(4'b1000, 4'h0, {16'h0080, 16'h0, 16'h0, 16'h0}, '0, TO, 32'hA5A5A5A5, 1'b0);
        // Out of range at the boundary and at the top.
        txn(4'b0001, 4'h0, {16'h0, 16'h0, 16'h0, 16'h0100}, '0, 0, 32'h1, 1'b0);
        txn(4'b0100, 4'h4, {16'h0, 16'hFFFF, 16'h0, 16'h0}, '0, 0, 32'h1, 1'b0);

        // Reset in WAIT_ACK.
        req = 4'b1000; req_we = '0; req_addr = {16'h0012, 48'h0}; req_wdata = '0;
        ptr = 0;  // reset below clears the pointer
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("mid_reg_req", 64'(reg_req), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_reg_req", 64'(reg_req), 64'd0);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        reg_ack = 1'b1;   // stray ack while idle
        @(negedge clk);
        reg_ack = 1'b0;
        chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
        chk("post_rst_reg_req", 64'(reg_req), 64'd0);
        txn(4'b1010, 4'h0, {16'h0001, 16'h0, 16'h0002, 16'h0}, '0, 2, 32'h0BADCAFE, 1'b0);

        for (int i = 0; i < 60; i++) rand_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
